dmem_arbiter: RTL and testbench

- Shares the single two-port data memory (one write port, one read port) between two requesters.
  - Requester 0 (m0): CPU_Top load/store unit.
  - Requester 1 (m1): debug/DMA loader.
- Write and read channels are arbitrated independently each cycle.
- Read data is returned to the owning requester with a tagged valid after the memory read latency.
- A starvation counter guarantees m1 forward progress when the CPU is given priority.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/dmem_arb_chan.sv | 55 +++++
 rtl/dmem_arbiter.sv | 103 ++++++++++
 tb/tb_dmem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared memory-system constants and the requester identity used by the
// data-memory arbiter.
package cpu_pkg;

  localparam int MEM_ADDR_WIDTH = 8;
  localparam int MEM_DATA_WIDTH = 32;
  localparam int DMEM_RD_LAT    = 1;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_e;

endpackage

// File: rtl/dmem_arb_chan.sv
// Two-input grant logic for one memory channel: fixed CPU priority with an
// m1 starvation escape, or plain round-robin.
module dmem_arb_chan
  import cpu_pkg::*;
#(
  parameter bit CPU_PRIO = 1'b1,
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  req_id_e    ptr_q, ptr_d;
  logic [3:0] wait_q, wait_d;
  logic       pick1;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    pick1 = req1_i;
    if (req0_i && req1_i) begin
      pick1 = CPU_PRIO ? (wait_q >= WAIT_LIM) : (ptr_q == REQ_DBG);
    end
    gnt0_o = rst && req0_i && !pick1;
    gnt1_o = rst && req1_i && pick1;

    ptr_d = ptr_q;
    if (gnt0_o)      ptr_d = REQ_DBG;
    else if (gnt1_o) ptr_d = REQ_CPU;

    wait_d = 4'd0;
    if (req1_i && !gnt1_o) begin
      wait_d = (wait_q >= WAIT_LIM) ? WAIT_LIM : wait_q + 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q  <= REQ_CPU;
      wait_q <= 4'd0;
    end else begin
      ptr_q  <= ptr_d;
      wait_q <= wait_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the one-write/one-read data memory between the CPU (m0) and the
// debug/DMA loader (m1); read data is returned with a per-owner valid.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_WIDTH,
  parameter int DATA_W   = MEM_DATA_WIDTH,
  parameter int RD_LAT   = DMEM_RD_LAT,
  parameter bit CPU_PRIO = 1'b1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_wen,
  input  logic [ADDR_W-1:0] m0_waddr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_wgnt,
  input  logic              m0_ren,
  input  logic [ADDR_W-1:0] m0_raddr,
  output logic              m0_rgnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_wen,
  input  logic [ADDR_W-1:0] m1_waddr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_wgnt,
  input  logic              m1_ren,
  input  logic [ADDR_W-1:0] m1_raddr,
  output logic              m1_rgnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic              dmem_wen,
  output logic [ADDR_W-1:0] dmem_waddr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_ren,
  output logic [ADDR_W-1:0] dmem_raddr,
  input  logic [DATA_W-1:0] dmem_rdata
);

  logic [RD_LAT-1:0] vld_q;
  req_id_e           own_q [RD_LAT];
  req_id_e           rd_own;

  dmem_arb_chan #(.CPU_PRIO(CPU_PRIO), .MAX_WAIT(MAX_WAIT)) u_wr_chan (
    .clk    (clk),
    .rst    (rst),
    .req0_i (m0_wen),
    .req1_i (m1_wen),
    .gnt0_o (m0_wgnt),
    .gnt1_o (m1_wgnt)
  );

  dmem_arb_chan #(.CPU_PRIO(CPU_PRIO), .MAX_WAIT(MAX_WAIT)) u_rd_chan (
    .clk    (clk),
    .rst    (rst),
    .req0_i (m0_ren),
    .req1_i (m1_ren),
    .gnt0_o (m0_rgnt),
    .gnt1_o (m1_rgnt)
  );

  always_comb begin
    dmem_wen   = m0_wgnt | m1_wgnt;
    dmem_waddr = '0;
    dmem_wdata = '0;
    if (m0_wgnt) begin
      dmem_waddr = m0_waddr;
      dmem_wdata = m0_wdata;
    end else if (m1_wgnt) begin
      dmem_waddr = m1_waddr;
      dmem_wdata = m1_wdata;
    end

    dmem_ren   = m0_rgnt | m1_rgnt;
    dmem_raddr = '0;
    if (m0_rgnt)      dmem_raddr = m0_raddr;
    else if (m1_rgnt) dmem_raddr = m1_raddr;

    rd_own = m1_rgnt ? REQ_DBG : REQ_CPU;
  end

  // NOTE: the owner pipeline is reset, unlike a data RAM, because a stale
  // valid here would deliver a response that was in flight at reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) own_q[i] <= REQ_CPU;
    end else begin
      vld_q[0] <= dmem_ren;
      own_q[0] <= rd_own;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        own_q[i] <= own_q[i-1];
      end
    end
  end

  assign m0_rvalid = vld_q[RD_LAT-1] && (own_q[RD_LAT-1] == REQ_CPU);
  assign m1_rvalid = vld_q[RD_LAT-1] && (own_q[RD_LAT-1] == REQ_DBG);
  assign m0_rdata  = rst ? dmem_rdata : '0;
  assign m1_rdata  = rst ? dmem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance 0 is CPU-priority with RD_LAT=2, instance 1
// is round-robin with RD_LAT=1; each has its own memory and reference model.
module tb_dmem_arbiter;
  import cpu_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int G_M0W = 0, G_M0R = 1, G_M1W = 2, G_M1R = 3;

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          ren;
    logic [AW-1:0] raddr;
  } mreq_t;

  typedef struct {
    int            due;
    bit            own;
    logic [DW-1:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  mreq_t rq [2][2];

  logic [1:0][3:0]    gnt_v;
  logic [1:0][1:0]    rv_v;
  logic [1:0][DW-1:0] rd0_v, rd1_v;
  logic [1:0][AW-1:0] waddr_v;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void decide(input bit prio, input bit r0, input bit r1, input bit last,
                                 input int waitc, input int mw, output bit g0, output bit g1);
    if (r0 && r1) begin
      g1 = prio ? (waitc >= mw) : (last == 1'b0);
      g0 = !g1;
    end else begin
      g0 = r0;
      g1 = r1;
    end
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam bit PRIO = (k == 0);
    localparam int LAT  = (k == 0) ? 2 : 1;
    localparam int MW   = 4;

    logic          m0_wgnt, m0_rgnt, m0_rvalid, m1_wgnt, m1_rgnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata, dmem_wdata, dmem_rdata;
    logic          dmem_wen, dmem_ren;
    logic [AW-1:0] dmem_waddr, dmem_raddr;

    dmem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .CPU_PRIO(PRIO), .MAX_WAIT(MW)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .m0_wen     (rq[k][0].wen),
      .m0_waddr   (rq[k][0].waddr),
      .m0_wdata   (rq[k][0].wdata),
      .m0_wgnt    (m0_wgnt),
      .m0_ren     (rq[k][0].ren),
      .m0_raddr   (rq[k][0].raddr),
      .m0_rgnt    (m0_rgnt),
      .m0_rdata   (m0_rdata),
      .m0_rvalid  (m0_rvalid),
      .m1_wen     (rq[k][1].wen),
      .m1_waddr   (rq[k][1].waddr),
      .m1_wdata   (rq[k][1].wdata),
      .m1_wgnt    (m1_wgnt),
      .m1_ren     (rq[k][1].ren),
      .m1_raddr   (rq[k][1].raddr),
      .m1_rgnt    (m1_rgnt),
      .m1_rdata   (m1_rdata),
      .m1_rvalid  (m1_rvalid),
      .dmem_wen   (dmem_wen),
      .dmem_waddr (dmem_waddr),
      .dmem_wdata (dmem_wdata),
      .dmem_ren   (dmem_ren),
      .dmem_raddr (dmem_raddr),
      .dmem_rdata (dmem_rdata)
    );

    assign gnt_v[k]   = {m1_rgnt, m1_wgnt, m0_rgnt, m0_wgnt};
    assign rv_v[k]    = {m1_rvalid, m0_rvalid};
    assign rd0_v[k]   = m0_rdata;
    assign rd1_v[k]   = m1_rdata;
    assign waddr_v[k] = dmem_waddr;

    // Memory with LAT-cycle read latency; a same-edge read sees old contents.
    bit   [DW-1:0] mem  [256];
    logic [DW-1:0] pipe [4];
    always @(posedge clk) begin
      if (dmem_ren) pipe[0] <= mem[dmem_raddr];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      if (dmem_wen) mem[dmem_waddr] <= dmem_wdata;
    end
    assign dmem_rdata = pipe[LAT-1];

    // Reference model: grant rules, last-winner/denied-run bookkeeping and a
    // queue of expected responses with their due cycle.
    bit [DW-1:0] mmem [256];
    resp_t       q [$];
    int          cyc = 0;
    bit          w_last = 1'b1, r_last = 1'b1;
    int          w_wait = 0, r_wait = 0;
    bit          eg0, eg1, er0, er1, ev0, ev1;
    logic [AW-1:0] ewa, era;
    logic [DW-1:0] ewd;

    always @(negedge clk) begin
      cyc++;
      if (!rst) begin
        check($sformatf("i%0d reset ctl", k),
              64'({gnt_v[k], rv_v[k], dmem_wen, dmem_ren, dmem_waddr, dmem_raddr}), 64'd0);
        check($sformatf("i%0d reset data", k), 64'({dmem_wdata, m0_rdata}), 64'd0);
        check($sformatf("i%0d reset m1_rdata", k), 64'(m1_rdata), 64'd0);
        w_last = 1'b1; r_last = 1'b1; w_wait = 0; r_wait = 0;
        q.delete();
      end else begin
        decide(PRIO, rq[k][0].wen, rq[k][1].wen, w_last, w_wait, MW, eg0, eg1);
        decide(PRIO, rq[k][0].ren, rq[k][1].ren, r_last, r_wait, MW, er0, er1);
        ewa = eg0 ? rq[k][0].waddr : (eg1 ? rq[k][1].waddr : '0);
        ewd = eg0 ? rq[k][0].wdata : (eg1 ? rq[k][1].wdata : '0);
        era = er0 ? rq[k][0].raddr : (er1 ? rq[k][1].raddr : '0);
        ev0 = (q.size() > 0) && (q[0].due == cyc) && !q[0].own;
        ev1 = (q.size() > 0) && (q[0].due == cyc) && q[0].own;

        check($sformatf("i%0d grants", k), 64'(gnt_v[k]), 64'({er1, eg1, er0, eg0}));
        check($sformatf("i%0d dmem write", k), 64'({dmem_wen, dmem_waddr, dmem_wdata}),
              64'({eg0 | eg1, ewa, ewd}));
        check($sformatf("i%0d dmem read", k), 64'({dmem_ren, dmem_raddr}), 64'({er0 | er1, era}));
        check($sformatf("i%0d rvalid", k), 64'(rv_v[k]), 64'({ev1, ev0}));
        if (ev0) check($sformatf("i%0d m0_rdata", k), 64'(m0_rdata), 64'(q[0].data));
        if (ev1) check($sformatf("i%0d m1_rdata", k), 64'(m1_rdata), 64'(q[0].data));

        if ((q.size() > 0) && (q[0].due == cyc)) void'(q.pop_front());
        if (er0 || er1) q.push_back('{due: cyc + LAT, own: er1, data: mmem[era]});
        if (eg0 || eg1) mmem[ewa] = ewd;

        w_wait = (rq[k][1].wen && !eg1) ? w_wait + 1 : 0;
        r_wait = (rq[k][1].ren && !er1) ? r_wait + 1 : 0;
        if (eg0)      w_last = 1'b0;
        else if (eg1) w_last = 1'b1;
        if (er0)      r_last = 1'b0;
        else if (er1) r_last = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         m1_gcyc;
    bit         m0g, m1g;
    logic [5:0] pat;
    logic [DW-1:0] fexp [5];

    for (int k = 0; k < 2; k++) for (int r = 0; r < 2; r++) rq[k][r] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset while an m0 read (RD_LAT=2) is in flight.
    rq[0][0].ren = 1'b1; rq[0][0].raddr = 8'h05;
    @(negedge clk); check("A m0_rgnt", 64'(gnt_v[0][G_M0R]), 64'd1);
    step(); rq[0][0].ren = 1'b0; rst = 1'b0;
    @(negedge clk); check("A rvalid in reset", 64'(rv_v[0]), 64'd0);
    check("A outputs in reset", 64'({gnt_v[0], waddr_v[0]}), 64'd0);
    step();
    @(negedge clk); check("A rvalid in reset 2", 64'(rv_v[0]), 64'd0);
    step(); rst = 1'b1;
    repeat (4) begin
      @(negedge clk); check("A rvalid after reset", 64'(rv_v[0]), 64'd0);
      step();
    end

    // Single requester write then read-back.
    rq[0][0].wen = 1'b1; rq[0][0].waddr = 8'h10; rq[0][0].wdata = 32'hDEADBEEF;
    @(negedge clk); check("B m0_wgnt", 64'(gnt_v[0][G_M0W]), 64'd1);
    step(); rq[0][0].wen = 1'b0; rq[0][0].ren = 1'b1; rq[0][0].raddr = 8'h10;
    @(negedge clk); check("B m0_rgnt", 64'(gnt_v[0][G_M0R]), 64'd1);
    step(); rq[0][0].ren = 1'b0;
    @(negedge clk); check("B rvalid early", 64'(rv_v[0]), 64'd0);
    step();
    @(negedge clk); check("B rvalid", 64'(rv_v[0]), 64'b01);
    check("B m0_rdata", 64'(rd0_v[0]), 64'hDEADBEEF);
    step();

    // Starvation escape with MAX_WAIT=4.
    rq[0][0].wen = 1'b1; rq[0][0].waddr = 8'h40; rq[0][0].wdata = 32'h0;
    rq[0][1].wen = 1'b1; rq[0][1].waddr = 8'h20; rq[0][1].wdata = 32'h12345678;
    m1_gcyc = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      m0g = gnt_v[0][G_M0W];
      m1g = gnt_v[0][G_M1W];
      if (m1g) begin
        if (m1_gcyc == 0) m1_gcyc = n;
        check("C dmem_waddr on escape", 64'(waddr_v[0]), 64'h20);
        check("C m0 denied on escape", 64'(m0g), 64'd0);
      end else begin
        check("C m0 granted", 64'(m0g), 64'd1);
      end
      step();
      if (m1g) rq[0][1].wen = 1'b0;
      if (m0g) begin
        rq[0][0].waddr = rq[0][0].waddr + 8'd1;
        rq[0][0].wdata = rq[0][0].wdata + 32'd1;
      end
    end
    rq[0][0].wen = 1'b0;
    check("C m1 grant cycle", 64'(m1_gcyc), 64'd5);

    // Write and read of the same address in one cycle from different requesters.
    rq[0][1].wen = 1'b1; rq[0][1].waddr = 8'h03; rq[0][1].wdata = 32'h00005555;
    @(negedge clk); check("D preload wgnt", 64'(gnt_v[0][G_M1W]), 64'd1);
    step(); rq[0][1].wen = 1'b0;
    rq[0][0].wen = 1'b1; rq[0][0].waddr = 8'h03; rq[0][0].wdata = 32'hAAAA0000;
    rq[0][1].ren = 1'b1; rq[0][1].raddr = 8'h03;
    @(negedge clk);
    check("D both granted", 64'({gnt_v[0][G_M0W], gnt_v[0][G_M1R]}), 64'b11);
    step(); rq[0][0].wen = 1'b0;
    @(negedge clk); check("D second read gnt", 64'(gnt_v[0][G_M1R]), 64'd1);
    step(); rq[0][1].ren = 1'b0;
    @(negedge clk); check("D first rvalid", 64'(rv_v[0]), 64'b10);
    check("D old data", 64'(rd1_v[0]), 64'h00005555);
    step();
    @(negedge clk); check("D second rvalid", 64'(rv_v[0]), 64'b10);
    check("D new data", 64'(rd1_v[0]), 64'hAAAA0000);
    step();

    // Round-robin reads on instance 1.
    rq[1][0].ren = 1'b1; rq[1][0].raddr = 8'h00;
    rq[1][1].ren = 1'b1; rq[1][1].raddr = 8'h01;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[i] = gnt_v[1][G_M1R];
      check("E one read grant", 64'(gnt_v[1][G_M0R] ^ gnt_v[1][G_M1R]), 64'd1);
      step();
    end
    rq[1][0].ren = 1'b0; rq[1][1].ren = 1'b0;
    check("E grant pattern", 64'(pat), 64'b101010);
    repeat (3) step();

    // Pipelined m1 reads with RD_LAT=1.
    fexp[0] = 32'h0; fexp[1] = 32'h11; fexp[2] = 32'h22; fexp[3] = 32'h33; fexp[4] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      rq[1][0].wen = 1'b1; rq[1][0].waddr = 8'(i); rq[1][0].wdata = fexp[i+1];
      @(negedge clk); check("F preload wgnt", 64'(gnt_v[1][G_M0W]), 64'd1);
      step();
    end
    rq[1][0].wen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rq[1][1].ren = (i < 3);
      rq[1][1].raddr = 8'(i);
      @(negedge clk);
      check("F m1_rvalid", 64'(rv_v[1][1]), 64'((i >= 1) && (i <= 3)));
      if ((i >= 1) && (i <= 3)) check("F m1_rdata", 64'(rd1_v[1]), 64'(fexp[i]));
      step();
    end
    rq[1][1].ren = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
